nco_sweep_ctrl: RTL and testbench

Phase-increment sequencer that directly feeds the phi_inc_i input of the NCO core. It steps the increment linearly from f_start toward f_stop, holds each value for a programmable dwell, and supports single-shot, sawtooth and triangle sweeps. It provides an update strobe and a sweep counter for downstream capture and debug.

---
 rtl/nco_sweep_pkg.sv | 43 ++++
 rtl/nco_sweep_dwell.sv | 32 +++
 rtl/nco_sweep_ctrl.sv | 169 ++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_sweep_pkg.sv
// nco_sweep_pkg: shared types and arithmetic for the NCO sweep controller.
//   mode_t        - sweep mode encodings (reserved value behaves as single)
//   state_t       - controller state encoding
//   nco_next_inc  - next phase increment, clamped to a limit, up or down
package nco_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Widest supported increment; callers zero-extend narrower operands.
  localparam int unsigned INC_MAX_W = 64;

  // Operands are zero-extended from the increment width, so a carry out of
  // that width shows up as a value above any legal limit and still clamps.
  // The extra top bit catches carry/borrow at the full 64-bit width.
  function automatic logic [INC_MAX_W-1:0] nco_next_inc(
    input logic [INC_MAX_W-1:0] phi,
    input logic [INC_MAX_W-1:0] step,
    input logic [INC_MAX_W-1:0] lim,
    input logic                 down
  );
    logic [INC_MAX_W:0] nxt;
    logic               clamp;
    if (down) begin
      nxt   = {1'b0, phi} - {1'b0, step};
      clamp = nxt[INC_MAX_W] || (nxt[INC_MAX_W-1:0] <= lim);
    end else begin
      nxt   = {1'b0, phi} + {1'b0, step};
      clamp = nxt[INC_MAX_W] || (nxt[INC_MAX_W-1:0] >= lim);
    end
    return clamp ? lim : nxt[INC_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/nco_sweep_dwell.sv
// nco_sweep_dwell: loadable down-counter timing how long each increment is held.
//   clk, reset_n - clock, async active-low reset (count cleared)
//   load         - load load_val this edge (takes priority over counting)
//   load_val     - reload value (hold length minus one)
//   tc           - terminal count: counter is zero
module nco_sweep_dwell
  import nco_sweep_pkg::*;
#(
  parameter int unsigned dwr = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load,
  input  logic [dwr-1:0] load_val,
  output logic           tc
);

  logic [dwr-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - dwr'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: phase-increment sweep sequencer feeding an NCO phi_inc input.
//   clk, reset_n      - clock, async active-low reset
//   start             - begin a sweep (accepted only when idle)
//   abort             - return to idle next edge, highest priority
//   mode              - 0 single, 1 sawtooth, 2 triangle, 3 as single
//   f_start/f_stop    - sweep end-points (unsigned)
//   f_step            - increment step
//   dwell             - each value is held dwell+1 cycles
//   phi_inc_o         - registered increment
//   phi_upd           - pulse in the first cycle of a new phi_inc_o value
//   busy              - sweep running
//   done              - pulse when a single sweep completes
//   dir_dn            - stepping down (triangle only)
//   sweep_cnt         - end-point events, wraps
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int unsigned apr = 32,
  parameter int unsigned dwr = 16,
  parameter int unsigned scw = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic [1:0]     mode,
  input  logic [apr-1:0] f_start,
  input  logic [apr-1:0] f_stop,
  input  logic [apr-1:0] f_step,
  input  logic [dwr-1:0] dwell,
  output logic [apr-1:0] phi_inc_o,
  output logic           phi_upd,
  output logic           busy,
  output logic           done,
  output logic           dir_dn,
  output logic [scw-1:0] sweep_cnt
);

  state_t         state, state_n;
  mode_t          sh_mode;
  logic [apr-1:0] sh_start, sh_stop, sh_step;
  logic [dwr-1:0] sh_dwell;
  logic           sh_load;

  logic           dw_load;
  logic [dwr-1:0] dw_val;
  logic           dw_tc;

  logic [apr-1:0] phi_n;
  logic           upd_n, busy_n, done_n, dir_n;
  logic [scw-1:0] cnt_n;

  logic           degen;
  logic           at_end;
  logic [apr-1:0] up_nxt, dn_nxt;

  nco_sweep_dwell #(.dwr(dwr)) u_dwell (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (dw_load),
    .load_val (dw_val),
    .tc       (dw_tc)
  );

  // Shadow copies of the sweep setup, captured only when a sweep starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_mode  <= MODE_SINGLE;
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= '0;
      sh_dwell <= '0;
    end else if (sh_load) begin
      sh_mode  <= mode_t'(mode);
      sh_start <= f_start;
      sh_stop  <= f_stop;
      sh_step  <= f_step;
      sh_dwell <= dwell;
    end
  end

  // With f_stop <= f_start the sweep collapses to one point: every
  // end-of-dwell is an end-point and the value never moves.
  assign degen  = (sh_stop <= sh_start);
  assign at_end = degen || (dir_dn ? (phi_inc_o == sh_start) : (phi_inc_o == sh_stop));

  assign up_nxt = apr'(nco_next_inc(INC_MAX_W'(phi_inc_o), INC_MAX_W'(sh_step),
                                    INC_MAX_W'(sh_stop), 1'b0));
  assign dn_nxt = apr'(nco_next_inc(INC_MAX_W'(phi_inc_o), INC_MAX_W'(sh_step),
                                    INC_MAX_W'(sh_start), 1'b1));

  always_comb begin
    state_n = state;
    phi_n   = phi_inc_o;
    upd_n   = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    dir_n   = dir_dn;
    cnt_n   = sweep_cnt;
    sh_load = 1'b0;
    dw_load = 1'b0;
    dw_val  = sh_dwell;

    if (abort) begin
      state_n = ST_IDLE;
      busy_n  = 1'b0;
      dir_n   = 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        sh_load = 1'b1;
        dw_load = 1'b1;
        dw_val  = dwell;
        phi_n   = f_start;
        upd_n   = 1'b1;
        busy_n  = 1'b1;
        dir_n   = 1'b0;
        state_n = ST_RUN;
      end
    end else if (dw_tc) begin
      dw_load = 1'b1;
      if (at_end) begin
        cnt_n = sweep_cnt + scw'(1);
        case (sh_mode)
          MODE_SAW: begin
            phi_n = sh_start;
            upd_n = 1'b1;
          end
          MODE_TRI: begin
            // Reverse first, then step in the new direction.
            dir_n = !dir_dn;
            if (!degen) begin
              phi_n = dir_dn ? up_nxt : dn_nxt;
              upd_n = 1'b1;
            end
          end
          default: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
          end
        endcase
      end else begin
        phi_n = dir_dn ? dn_nxt : up_nxt;
        upd_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      phi_inc_o <= '0;
      phi_upd   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dir_dn    <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      state     <= state_n;
      phi_inc_o <= phi_n;
      phi_upd   <= upd_n;
      busy      <= busy_n;
      done      <= done_n;
      dir_dn    <= dir_n;
      sweep_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: checks nco_sweep_ctrl against a trace model that lists
// the swept values, their hold times and the end-point reactions per mode.
module tb_nco_sweep_ctrl;

  localparam int unsigned APR = 32;
  localparam int unsigned DWR = 16;
  localparam int unsigned SCW = 4;

  logic           clk, reset_n, start, abort;
  logic [1:0]     mode;
  logic [APR-1:0] f_start, f_stop, f_step;
  logic [DWR-1:0] dwell;
  logic [APR-1:0] phi_inc_o;
  logic           phi_upd, busy, done, dir_dn;
  logic [SCW-1:0] sweep_cnt;

  nco_sweep_ctrl #(.apr(APR), .dwr(DWR), .scw(SCW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .phi_inc_o (phi_inc_o),
    .phi_upd   (phi_upd),
    .busy      (busy),
    .done      (done),
    .dir_dn    (dir_dn),
    .sweep_cnt (sweep_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    longint unsigned phi;
    bit              upd;
    bit              busy;
    bit              done;
    bit              dir;
    int unsigned     cnt;
  } exp_t;

  exp_t            tr[$];
  int unsigned     m_cnt;
  longint unsigned m_phi;
  int              n_checks;
  int              n_errs;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic longint unsigned step_val(input longint unsigned v, input longint unsigned fs,
                                               input longint unsigned fp, input longint unsigned st,
                                               input bit down);
    if (!down) return (v + st >= fp) ? fp : v + st;
    return (v <= fs + st) ? fs : v - st;
  endfunction

  // Expected per-cycle outputs; entry i is the cycle after edge i (start at edge 0).
  function automatic void build_trace(input int md, input longint unsigned fs, input longint unsigned fp,
                                      input longint unsigned st, input int dw, input int ncyc,
                                      input int abort_at, input int unsigned cnt0);
    longint unsigned v = fs;
    bit dir = 0, upd_next = 1, finished = 0, done_pend = 0, degen, at_end;
    int unsigned cnt = cnt0;
    exp_t e;
    tr.delete();
    while (tr.size() < ncyc) begin
      if (finished) begin
        e = '{phi: v, upd: 0, busy: 0, done: done_pend, dir: 0, cnt: cnt};
        done_pend = 0;
        tr.push_back(e);
      end else begin
        for (int k = 0; k <= dw; k++) begin
          e = '{phi: v, upd: (upd_next && k == 0), busy: 1, done: 0, dir: dir, cnt: cnt};
          tr.push_back(e);
        end
        degen    = (fp <= fs);
        at_end   = degen || (dir ? (v == fs) : (v == fp));
        upd_next = 1;
        if (at_end) begin
          cnt = (cnt + 1) % (1 << SCW);
          if (md == 1) v = fs;
          else if (md == 2) begin
            dir = !dir;
            if (degen) upd_next = 0;
            else v = step_val(v, fs, fp, st, dir);
          end else begin
            finished  = 1;
            done_pend = 1;
          end
        end else begin
          v = step_val(v, fs, fp, st, dir);
        end
      end
    end
    while (tr.size() > ncyc) void'(tr.pop_back());
    if (abort_at > 0 && abort_at < ncyc) begin
      for (int i = abort_at; i < ncyc; i++)
        tr[i] = '{phi: tr[abort_at-1].phi, upd: 0, busy: 0, done: 0, dir: 0, cnt: tr[abort_at-1].cnt};
    end
  endfunction

  task automatic scramble_inputs();
    mode    = 2'($urandom);
    f_start = $urandom;
    f_stop  = $urandom;
    f_step  = $urandom;
    dwell   = DWR'($urandom);
  endtask

  task automatic compare_cycle(input int c, input exp_t e);
    check_val($sformatf("phi c%0d", c), 64'(phi_inc_o), e.phi);
    check_val($sformatf("upd c%0d", c), 64'(phi_upd), 64'(e.upd));
    check_val($sformatf("busy c%0d", c), 64'(busy), 64'(e.busy));
    check_val($sformatf("done c%0d", c), 64'(done), 64'(e.done));
    check_val($sformatf("dir c%0d", c), 64'(dir_dn), 64'(e.dir));
    check_val($sformatf("cnt c%0d", c), 64'(sweep_cnt), 64'(e.cnt));
  endtask

  task automatic run_sweep(input int md, input longint unsigned fs, input longint unsigned fp,
                           input longint unsigned st, input int dw, input int ncyc, input int abort_at);
    exp_t last;
    build_trace(md, fs, fp, st, dw, ncyc, abort_at, m_cnt);
    @(negedge clk);
    mode    = 2'(md);
    f_start = APR'(fs);
    f_stop  = APR'(fp);
    f_step  = APR'(st);
    dwell   = DWR'(dw);
    start   = 1'b1;
    abort   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      compare_cycle(c, tr[c-1]);
      scramble_inputs();
      if (c == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
      end else begin
        abort = 1'b0;
        start = tr[c-1].busy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    last = tr[ncyc-1];
    if (last.busy) begin
      abort = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      last = '{phi: last.phi, upd: 0, busy: 0, done: 0, dir: 0, cnt: last.cnt};
      compare_cycle(ncyc + 1, last);
    end
    abort = 1'b0;
    start = 1'b0;
    m_cnt = last.cnt;
    m_phi = last.phi;
  endtask

  initial begin
    longint unsigned fs, fp, st;
    int md, dw, ncyc, ab, sel;
    n_checks = 0;
    n_errs   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    scramble_inputs();
    #2;
    check_val("rst phi", 64'(phi_inc_o), 0);
    check_val("rst busy", 64'(busy), 0);
    check_val("rst upd", 64'(phi_upd), 0);
    check_val("rst cnt", 64'(sweep_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_cnt = 0;
    m_phi = 0;

    run_sweep(0, 100, 130, 10, 2, 15, 0);
    run_sweep(0, 100, 125, 10, 0, 7, 0);
    run_sweep(0, 64'hFFFF_FFF0, 64'hFFFF_FFFF, 64'h20, 0, 5, 0);
    run_sweep(2, 100, 120, 10, 0, 12, 0);
    run_sweep(1, 100, 120, 10, 1, 12, 8);
    run_sweep(1, 200, 150, 5, 0, 20, 0);
    run_sweep(2, 200, 200, 5, 1, 10, 0);
    run_sweep(0, 100, 200, 0, 1, 10, 0);
    run_sweep(3, 40, 70, 15, 0, 6, 0);

    // abort together with start while idle: start must be dropped
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("idle abort busy", 64'(busy), 0);
      check_val("idle abort upd", 64'(phi_upd), 0);
      check_val("idle abort phi", 64'(phi_inc_o), m_phi);
      check_val("idle abort cnt", 64'(sweep_cnt), 64'(m_cnt));
    end

    // asynchronous reset in the middle of a sweep
    @(negedge clk);
    mode = 2'd1; f_start = 100; f_stop = 150; f_step = 10; dwell = 0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst phi", 64'(phi_inc_o), 0);
    check_val("arst upd", 64'(phi_upd), 0);
    check_val("arst busy", 64'(busy), 0);
    check_val("arst done", 64'(done), 0);
    check_val("arst dir", 64'(dir_dn), 0);
    check_val("arst cnt", 64'(sweep_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("post rst upd", 64'(phi_upd), 0);
      check_val("post rst busy", 64'(busy), 0);
      check_val("post rst done", 64'(done), 0);
      check_val("post rst phi", 64'(phi_inc_o), 0);
    end
    m_cnt = 0;
    m_phi = 0;

    for (int r = 0; r < 25; r++) begin
      md  = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        fs = 64'hFFFF_FF00 + $urandom_range(0, 'h80);
        fp = fs + $urandom_range(0, 'h7F);
        st = $urandom_range(0, 'h100);
      end else if (sel == 1) begin
        fs = $urandom_range(50, 500);
        fp = fs - $urandom_range(0, 50);
        st = $urandom_range(0, 20);
      end else begin
        fs = $urandom_range(0, 1000);
        fp = fs + $urandom_range(1, 150);
        st = $urandom_range(0, 40);
      end
      dw   = int'($urandom_range(0, 3));
      ncyc = int'($urandom_range(20, 70));
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, ncyc - 1)) : 0;
      run_sweep(md, fs, fp, st, dw, ncyc, ab);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
